// File: rtl/ospi_master.sv
// Octal-SPI initiator (SDR, mode 0). It sends the command, the address, optional dummy beats
// and then the write or read data, one byte per OSPI clock on IO[7:0].
//
// state | meaning
// IDLE  | bus released, waiting for start
// CMD   | command beat
// ADDR  | address beats, MSB byte first
// DUMMY | turnaround beats before read data, IO released
// WDATA | write beats, one tx handshake per beat (may stall with clock low)
// RDATA | read beats, io_in captured on each rising OSPI_CLK
// CSH   | chip select high for the minimum deselect time
// DONE  | one-cycle completion pulse, new start accepted
module ospi_master #(
    parameter int CLK_DIV      = 2,
    parameter int ADDR_BYTES   = 1,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [7:0]              cmd,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic                    is_read,
    input  logic [4:0]              len,
    output logic                    busy,
    output logic                    done,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic                    OSPI_CLK,
    output logic                    OSPI_CS,
    output logic [7:0]              io_out,
    output logic                    io_oe,
    input  logic [7:0]              io_in
);
    localparam int AW    = 8 * ADDR_BYTES;
    localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] HALF_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] CSH_LOAD   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]       ADDR_LOAD  = 5'(ADDR_BYTES - 1);
    localparam logic [4:0]       DUMMY_LOAD = 5'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_CSH, S_DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       beat_cnt;
    logic             stall;
    logic [AW-1:0]    addr_sh;
    logic             is_read_q;
    logic [4:0]       len_q;

    logic in_beat;
    logic rise;
    logic pre_end;
    logic next_write;

    always_comb begin
        in_beat    = 1'b0;
        rise       = 1'b0;
        pre_end    = 1'b0;
        next_write = 1'b0;
        in_beat = !stall && (state inside {S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA});
        rise    = in_beat && !OSPI_CLK && (div_cnt == '0);
        if (CLK_DIV == 1)
            pre_end = rise;
        else
            pre_end = in_beat && OSPI_CLK && (div_cnt == DIV_W'(1));
        next_write = ((state == S_ADDR) && (beat_cnt == 5'd0) && !is_read_q && (len_q != 5'd0)) ||
                     ((state == S_WDATA) && (beat_cnt != 5'd0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            beat_cnt  <= 5'd0;
            stall     <= 1'b0;
            addr_sh   <= '0;
            is_read_q <= 1'b0;
            len_q     <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            OSPI_CLK  <= 1'b0;
            OSPI_CS   <= 1'b1;
            io_out    <= 8'h00;
            io_oe     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;

            // tx_ready rises for the last high cycle of the previous beat, so an
            // immediately valid byte lands on io_out exactly as the write beat starts.
            if (pre_end && next_write)
                tx_ready <= 1'b1;

            if (rise && (state == S_RDATA)) begin
                rx_data  <= io_in;
                rx_valid <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_sh   <= addr;
                        is_read_q <= is_read;
                        len_q     <= len;
                        busy      <= 1'b1;
                        OSPI_CS   <= 1'b0;
                        OSPI_CLK  <= 1'b0;
                        io_oe     <= 1'b1;
                        io_out    <= cmd;
                        div_cnt   <= HALF_LOAD;
                        stall     <= 1'b0;
                        state     <= S_CMD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_CSH: begin
                    if (div_cnt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end

                default: begin
                    if (stall) begin
                        if (tx_valid) begin
                            io_out   <= tx_data;
                            tx_ready <= 1'b0;
                            stall    <= 1'b0;
                            div_cnt  <= HALF_LOAD;
                        end
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!OSPI_CLK) begin
                        OSPI_CLK <= 1'b1;
                        div_cnt  <= HALF_LOAD;
                    end else begin
                        OSPI_CLK <= 1'b0;
                        div_cnt  <= HALF_LOAD;
                        case (state)
                            S_CMD: begin
                                io_out   <= addr_sh[AW-1 -: 8];
                                addr_sh  <= addr_sh << 8;
                                beat_cnt <= ADDR_LOAD;
                                state    <= S_ADDR;
                            end
                            S_ADDR: begin
                                if (beat_cnt != 5'd0) begin
                                    io_out   <= addr_sh[AW-1 -: 8];
                                    addr_sh  <= addr_sh << 8;
                                    beat_cnt <= beat_cnt - 5'd1;
                                end else if (is_read_q && (len_q != 5'd0)) begin
                                    io_oe <= 1'b0;
                                    if (DUMMY_CYCLES > 0) begin
                                        beat_cnt <= DUMMY_LOAD;
                                        state    <= S_DUMMY;
                                    end else begin
                                        beat_cnt <= len_q - 5'd1;
                                        state    <= S_RDATA;
                                    end
                                end else if (len_q != 5'd0) begin
                                    beat_cnt <= len_q - 5'd1;
                                    state    <= S_WDATA;
                                    if (tx_valid) begin
                                        io_out   <= tx_data;
                                        tx_ready <= 1'b0;
                                    end else begin
                                        stall <= 1'b1;
                                    end
                                end else begin
                                    OSPI_CS <= 1'b1;
                                    io_oe   <= 1'b0;
                                    div_cnt <= CSH_LOAD;
                                    state   <= S_CSH;
                                end
                            end
                            S_DUMMY: begin
                                if (beat_cnt != 5'd0) begin
                                    beat_cnt <= beat_cnt - 5'd1;
                                end else begin
                                    beat_cnt <= len_q - 5'd1;
                                    state    <= S_RDATA;
                                end
                            end
                            S_WDATA: begin
                                if (beat_cnt != 5'd0) begin
                                    beat_cnt <= beat_cnt - 5'd1;
                                    if (tx_valid) begin
                                        io_out   <= tx_data;
                                        tx_ready <= 1'b0;
                                    end else begin
                                        stall <= 1'b1;
                                    end
                                end else begin
                                    OSPI_CS <= 1'b1;
                                    io_oe   <= 1'b0;
                                    div_cnt <= CSH_LOAD;
                                    state   <= S_CSH;
                                end
                            end
                            default: begin
                                if (beat_cnt != 5'd0) begin
                                    beat_cnt <= beat_cnt - 5'd1;
                                end else begin
                                    OSPI_CS <= 1'b1;
                                    io_oe   <= 1'b0;
                                    div_cnt <= CSH_LOAD;
                                    state   <= S_CSH;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
